// File: rtl/avr_pkg.sv
// Shared AVR fetch definitions: NOP encoding, two-word opcode patterns and queue entry type.
// avr_is_two_word() is only consulted by avr_ifetch when IFETCH_TWO_WORD_EN is defined.
package avr_pkg;

   localparam int          AVR_AW  = 16;
   localparam logic [15:0] AVR_NOP = 16'h0000;

   // JMP/CALL: 1001_010x_xxxx_11xx, LDS/STS: 1001_00xx_xxxx_0000
   localparam logic [15:0] AVR_JMP_CALL_MASK  = 16'hFE0C;
   localparam logic [15:0] AVR_JMP_CALL_MATCH = 16'h940C;
   localparam logic [15:0] AVR_LDS_STS_MASK   = 16'hFC0F;
   localparam logic [15:0] AVR_LDS_STS_MATCH  = 16'h9000;

   typedef struct packed {
      logic [15:0]       word;
      logic [AVR_AW-1:0] pc;
   } avr_qentry_t;

   function automatic logic avr_is_two_word(input logic [15:0] word);
      return ((word & AVR_JMP_CALL_MASK) == AVR_JMP_CALL_MATCH) ||
             ((word & AVR_LDS_STS_MASK) == AVR_LDS_STS_MATCH);
   endfunction

endpackage

// File: rtl/avr_ifetch_fifo.sv
// Prefetch queue: circular buffer of {word, pc} with one push, pop of one or two, and flush.
// Exposes the head entry and the entry behind it so a two-word instruction can be presented whole.
module avr_ifetch_fifo #(
   parameter int  AW    = 16,
   parameter int  DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic          push_i,
   input  logic [15:0]   push_word_i,
   input  logic [AW-1:0] push_pc_i,
   input  logic          pop1_i,
   input  logic          pop2_i,
   output logic [CW-1:0] count_o,
   output logic [15:0]   head_word_o,
   output logic [AW-1:0] head_pc_o,
   output logic [15:0]   head1_word_o,
   output logic [AW-1:0] head1_pc_o
);

   logic [15:0]   word_q [DEPTH];
   logic [AW-1:0] pc_q   [DEPTH];
   logic [PW-1:0] rd_q;
   logic [PW-1:0] wr_q;
   logic [PW-1:0] rd1_w;
   logic [CW-1:0] count_q;
   logic [1:0]    pop_n_w;

   assign pop_n_w = pop2_i ? 2'd2 : {1'b0, pop1_i};
   assign rd1_w   = rd_q + PW'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         rd_q    <= '0;
         wr_q    <= '0;
         count_q <= '0;
      end else begin
         if (push_i) begin
            wr_q <= wr_q + PW'(1);
         end
         rd_q    <= rd_q + PW'(pop_n_w);
         count_q <= count_q + CW'(push_i) - CW'(pop_n_w);
      end
   end

   // Storage needs no reset; occupancy alone decides what is meaningful.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i && !rst_i) begin
         word_q[wr_q] <= push_word_i;
         pc_q[wr_q]   <= push_pc_i;
      end
   end

   assign count_o      = count_q;
   assign head_word_o  = word_q[rd_q];
   assign head_pc_o    = pc_q[rd_q];
   assign head1_word_o = word_q[rd1_w];
   assign head1_pc_o   = pc_q[rd1_w];

endmodule

// File: rtl/avr_ifetch.sv
// Instruction fetch unit: PC-driven word reads into a prefetch queue, one instruction per cycle out.
// Optional feature macro IFETCH_TWO_WORD_EN: present JMP/CALL/LDS/STS together with their second word.
module avr_ifetch
   import avr_pkg::*;
#(
   parameter int AW    = 16,
   parameter int DEPTH = 4
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          pc_load_i,
   input  logic [AW-1:0] pc_target_i,
   input  logic          advance_i,
   output logic [15:0]   instr_o,
   output logic [15:0]   instr_ext_o,
   output logic          instr_valid_o,
   output logic [AW-1:0] instr_pc_o,
   output logic          mem_rd_o,
   output logic [AW-1:0] mem_addr_o,
   input  logic [15:0]   mem_rdata_i
);

   localparam int          CW      = $clog2(DEPTH) + 1;
   localparam logic [CW:0] DEPTH_L = (CW+1)'(DEPTH);

   logic [AW-1:0] fptr_q;
   logic [AW-1:0] infl_pc_q;
   logic          infl_q;
   logic          infl_ep_q;
   logic          epoch_q;

   logic [CW-1:0] count_w;
   logic [15:0]   head_word_w;
   logic [AW-1:0] head_pc_w;
   logic [15:0]   head1_word_w;
   logic [AW-1:0] head1_pc_w;
   logic          valid_w;
   logic          adv_w;
   logic          pop1_w;
   logic          pop2_w;
   logic [1:0]    pop_n_w;
   logic          push_w;
   logic          issue_w;
   logic [CW:0]   fill_w;
   logic          unused_head1;

   // A return is kept only if no redirect has happened since it was issued.
   assign push_w = infl_q && (infl_ep_q == epoch_q) && !pc_load_i && !rst_i;
   assign adv_w  = advance_i && valid_w && !pc_load_i;

`ifdef IFETCH_TWO_WORD_EN
   logic head_two_w;
   assign head_two_w   = avr_is_two_word(head_word_w);
   assign valid_w      = head_two_w ? (count_w >= CW'(2)) : (count_w != '0);
   assign pop1_w       = adv_w && !head_two_w;
   assign pop2_w       = adv_w && head_two_w;
   assign instr_ext_o  = (valid_w && head_two_w) ? head1_word_w : AVR_NOP;
   assign unused_head1 = ^head1_pc_w;
`else
   assign valid_w      = (count_w != '0);
   assign pop1_w       = adv_w;
   assign pop2_w       = 1'b0;
   assign instr_ext_o  = AVR_NOP;
   assign unused_head1 = ^{head1_word_w, head1_pc_w};
`endif

   assign pop_n_w = pop2_w ? 2'd2 : {1'b0, pop1_w};
   assign fill_w  = {1'b0, count_w} + (CW+1)'(infl_q) - (CW+1)'(pop_n_w);
   assign issue_w = !rst_i && !pc_load_i && (fill_w < DEPTH_L);

   avr_ifetch_fifo #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (pc_load_i),
      .push_i       (push_w),
      .push_word_i  (mem_rdata_i),
      .push_pc_i    (infl_pc_q),
      .pop1_i       (pop1_w),
      .pop2_i       (pop2_w),
      .count_o      (count_w),
      .head_word_o  (head_word_w),
      .head_pc_o    (head_pc_w),
      .head1_word_o (head1_word_w),
      .head1_pc_o   (head1_pc_w)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fptr_q    <= '0;
         infl_pc_q <= '0;
         infl_q    <= 1'b0;
         infl_ep_q <= 1'b0;
         epoch_q   <= 1'b0;
      end else if (pc_load_i) begin
         fptr_q  <= pc_target_i;
         infl_q  <= 1'b0;
         epoch_q <= ~epoch_q;
      end else begin
         infl_q    <= issue_w;
         infl_ep_q <= epoch_q;
         infl_pc_q <= fptr_q;
         if (issue_w) begin
            fptr_q <= fptr_q + AW'(1);
         end
      end
   end

   assign mem_rd_o      = issue_w;
   assign mem_addr_o    = fptr_q;
   assign instr_valid_o = valid_w;
   assign instr_o       = valid_w ? head_word_w : AVR_NOP;
   assign instr_pc_o    = valid_w ? head_pc_w : '0;

endmodule

// File: tb/tb_avr_ifetch.sv
// Self-checking bench for avr_ifetch: directed scenarios plus a randomized run against a program-order model.
module tb_avr_ifetch;

   localparam int AW    = 16;
   localparam int DEPTH = 4;
`ifdef IFETCH_TWO_WORD_EN
   localparam bit TWO_EN = 1'b1;
`else
   localparam bit TWO_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pc_load = 1'b0;
   logic [AW-1:0] pc_target = '0;
   logic          advance = 1'b0;
   logic [15:0]   mem_rdata = 16'h0;
   logic [15:0]   instr_o;
   logic [15:0]   instr_ext_o;
   logic          instr_valid_o;
   logic [AW-1:0] instr_pc_o;
   logic          mem_rd_o;
   logic [AW-1:0] mem_addr_o;

   int checks = 0;
   int errors = 0;

   avr_ifetch #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .pc_load_i     (pc_load),
      .pc_target_i   (pc_target),
      .advance_i     (advance),
      .instr_o       (instr_o),
      .instr_ext_o   (instr_ext_o),
      .instr_valid_o (instr_valid_o),
      .instr_pc_o    (instr_pc_o),
      .mem_rd_o      (mem_rd_o),
      .mem_addr_o    (mem_addr_o),
      .mem_rdata_i   (mem_rdata)
   );

   always #5 clk = ~clk;

   // Program image: a JMP at 0x0200, everything else is address + 0x1000.
   function automatic logic [15:0] mem_fn(input logic [15:0] a);
      if (a == 16'h0200) return 16'h940C;
      if (a == 16'h0201) return 16'h0123;
      return a + 16'h1000;
   endfunction

   function automatic bit is_two(input logic [15:0] w);
      return TWO_EN && (((w & 16'hFE0C) == 16'h940C) || ((w & 16'hFC0F) == 16'h9000));
   endfunction

   // Synchronous memory: data one cycle after the read, junk otherwise.
   always @(posedge clk) begin
      if (mem_rd_o) mem_rdata <= mem_fn(mem_addr_o);
      else          mem_rdata <= 16'($urandom);
   end

   task automatic drive(input logic adv, input logic load, input logic [AW-1:0] tgt);
      @(negedge clk);
      rst       = 1'b0;
      advance   = adv;
      pc_load   = load;
      pc_target = tgt;
      #1;
   endtask

   task automatic hold_reset();
      @(negedge clk);
      rst     = 1'b1;
      advance = 1'b0;
      pc_load = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      hold_reset();
      @(negedge clk); #1;
      checks++; if (instr_o !== 16'h0) begin errors++; $display("FAIL reset_instr got=%h exp=0000", instr_o); end
      checks++; if (instr_ext_o !== 16'h0) begin errors++; $display("FAIL reset_ext got=%h exp=0000", instr_ext_o); end
      checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", instr_valid_o); end
      checks++; if (instr_pc_o !== '0) begin errors++; $display("FAIL reset_pc got=%h exp=0000", instr_pc_o); end
      checks++; if (mem_rd_o !== 1'b0) begin errors++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd_o); end
      checks++; if (mem_addr_o !== '0) begin errors++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr_o); end
   endtask

   task automatic test_stream();
      hold_reset();
      @(negedge clk);
      drive(1'b1, 1'b0, '0);
      checks++; if (mem_rd_o !== 1'b1 || mem_addr_o !== 16'h0) begin
         errors++; $display("FAIL stream_c0_issue got rd=%b addr=%h exp rd=1 addr=0000", mem_rd_o, mem_addr_o); end
      checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL stream_c0_valid got=%b exp=0", instr_valid_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL stream_c1_valid got=%b exp=0", instr_valid_o); end
      for (int k = 0; k < 20; k++) begin
         drive(1'b1, 1'b0, '0);
         checks++;
         if (instr_valid_o !== 1'b1 || instr_o !== 16'h1000 + 16'(k) || instr_pc_o !== 16'(k)) begin
            errors++;
            $display("FAIL stream_k%0d got v=%b instr=%h pc=%h exp v=1 instr=%h pc=%h",
                     k, instr_valid_o, instr_o, instr_pc_o, 16'h1000 + 16'(k), 16'(k));
         end
      end
   endtask

   task automatic test_stall();
      int rd_cnt;
      rd_cnt = 0;
      hold_reset();
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         drive(1'b0, 1'b0, '0);
         if (mem_rd_o === 1'b1) rd_cnt++;
         if (c >= 2) begin
            checks++;
            if (instr_valid_o !== 1'b1 || instr_o !== 16'h1000) begin
               errors++; $display("FAIL stall_hold_c%0d got v=%b instr=%h exp v=1 instr=1000", c, instr_valid_o, instr_o);
            end
         end
      end
      checks++; if (rd_cnt != DEPTH) begin errors++; $display("FAIL stall_reads got=%0d exp=%0d", rd_cnt, DEPTH); end
      for (int k = 0; k < 8; k++) begin
         drive(1'b1, 1'b0, '0);
         checks++;
         if (instr_valid_o !== 1'b1 || instr_o !== 16'h1000 + 16'(k) || instr_pc_o !== 16'(k)) begin
            errors++;
            $display("FAIL stall_resume_k%0d got v=%b instr=%h pc=%h exp instr=%h", k, instr_valid_o, instr_o, instr_pc_o, 16'h1000 + 16'(k));
         end
      end
   endtask

   task automatic test_redirect();
      hold_reset();
      @(negedge clk);
      for (int c = 0; c < 5; c++) drive(1'b1, 1'b0, '0);
      drive(1'b0, 1'b1, 16'h0040);
      checks++; if (mem_rd_o !== 1'b0) begin errors++; $display("FAIL redir_n_rd got=%b exp=0", mem_rd_o); end
      drive(1'b0, 1'b0, '0);
      checks++; if (mem_rd_o !== 1'b1 || mem_addr_o !== 16'h0040) begin
         errors++; $display("FAIL redir_n1_issue got rd=%b addr=%h exp rd=1 addr=0040", mem_rd_o, mem_addr_o); end
      checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL redir_n1_valid got=%b exp=0", instr_valid_o); end
      drive(1'b0, 1'b0, '0);
      checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL redir_n2_valid got=%b exp=0", instr_valid_o); end
      drive(1'b0, 1'b0, '0);
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== 16'h1040 || instr_pc_o !== 16'h0040) begin
         errors++; $display("FAIL redir_n3 got v=%b instr=%h pc=%h exp v=1 instr=1040 pc=0040", instr_valid_o, instr_o, instr_pc_o); end
   endtask

   task automatic test_redirect_advance();
      drive(1'b1, 1'b1, 16'h0100);
      checks++; if (instr_valid_o !== 1'b1) begin errors++; $display("FAIL redadv_n_valid got=%b exp=1", instr_valid_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (instr_valid_o !== 1'b0 || mem_addr_o !== 16'h0100) begin
         errors++; $display("FAIL redadv_n1 got v=%b addr=%h exp v=0 addr=0100", instr_valid_o, mem_addr_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL redadv_n2_valid got=%b exp=0", instr_valid_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== 16'h1100 || instr_pc_o !== 16'h0100) begin
         errors++; $display("FAIL redadv_n3 got v=%b instr=%h pc=%h exp instr=1100 pc=0100", instr_valid_o, instr_o, instr_pc_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (instr_o !== 16'h1101 || instr_pc_o !== 16'h0101) begin
         errors++; $display("FAIL redadv_n4 got instr=%h pc=%h exp instr=1101 pc=0101", instr_o, instr_pc_o); end
   endtask

   task automatic test_wrap();
      drive(1'b1, 1'b1, 16'hFFFE);
      drive(1'b1, 1'b0, '0);
      checks++; if (mem_addr_o !== 16'hFFFE) begin errors++; $display("FAIL wrap_addr0 got=%h exp=FFFE", mem_addr_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (mem_addr_o !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr1 got=%h exp=FFFF", mem_addr_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (mem_rd_o !== 1'b1 || mem_addr_o !== 16'h0000) begin
         errors++; $display("FAIL wrap_addr2 got rd=%b addr=%h exp rd=1 addr=0000", mem_rd_o, mem_addr_o); end
      checks++; if (instr_o !== 16'h0FFE || instr_pc_o !== 16'hFFFE) begin
         errors++; $display("FAIL wrap_i0 got instr=%h pc=%h exp instr=0FFE pc=FFFE", instr_o, instr_pc_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (instr_o !== 16'h0FFF || instr_pc_o !== 16'hFFFF) begin
         errors++; $display("FAIL wrap_i1 got instr=%h pc=%h exp instr=0FFF pc=FFFF", instr_o, instr_pc_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (instr_o !== 16'h1000 || instr_pc_o !== 16'h0000) begin
         errors++; $display("FAIL wrap_i2 got instr=%h pc=%h exp instr=1000 pc=0000", instr_o, instr_pc_o); end
   endtask

   task automatic test_two_word();
      drive(1'b0, 1'b1, 16'h0200);
      drive(1'b0, 1'b0, '0);
      drive(1'b0, 1'b0, '0);
`ifdef IFETCH_TWO_WORD_EN
      drive(1'b0, 1'b0, '0);
      checks++; if (instr_valid_o !== 1'b0) begin errors++; $display("FAIL two_half got v=%b exp=0", instr_valid_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== 16'h940C || instr_ext_o !== 16'h0123 || instr_pc_o !== 16'h0200) begin
         errors++; $display("FAIL two_jmp got v=%b instr=%h ext=%h pc=%h exp v=1 instr=940C ext=0123 pc=0200",
                            instr_valid_o, instr_o, instr_ext_o, instr_pc_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== 16'h1202 || instr_ext_o !== 16'h0 || instr_pc_o !== 16'h0202) begin
         errors++; $display("FAIL two_next got v=%b instr=%h ext=%h pc=%h exp v=1 instr=1202 ext=0000 pc=0202",
                            instr_valid_o, instr_o, instr_ext_o, instr_pc_o); end
`else
      drive(1'b1, 1'b0, '0);
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== 16'h940C || instr_ext_o !== 16'h0 || instr_pc_o !== 16'h0200) begin
         errors++; $display("FAIL one_jmp got v=%b instr=%h ext=%h pc=%h exp v=1 instr=940C ext=0000 pc=0200",
                            instr_valid_o, instr_o, instr_ext_o, instr_pc_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (instr_o !== 16'h0123 || instr_pc_o !== 16'h0201) begin
         errors++; $display("FAIL one_next got instr=%h pc=%h exp instr=0123 pc=0201", instr_o, instr_pc_o); end
`endif
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 6; c++) drive(1'b1, 1'b0, '0);
      hold_reset();
      checks++; if (mem_rd_o !== 1'b0) begin errors++; $display("FAIL rstmid_rd got=%b exp=0", mem_rd_o); end
      @(negedge clk); #1;
      checks++; if ({instr_o, instr_ext_o, instr_valid_o, instr_pc_o, mem_rd_o, mem_addr_o} !== '0) begin
         errors++; $display("FAIL rstmid_outputs got instr=%h ext=%h v=%b pc=%h rd=%b addr=%h exp all 0",
                            instr_o, instr_ext_o, instr_valid_o, instr_pc_o, mem_rd_o, mem_addr_o); end
      drive(1'b1, 1'b0, '0);
      checks++; if (mem_rd_o !== 1'b1 || mem_addr_o !== 16'h0) begin
         errors++; $display("FAIL rstmid_c0 got rd=%b addr=%h exp rd=1 addr=0000", mem_rd_o, mem_addr_o); end
      drive(1'b1, 1'b0, '0);
      drive(1'b1, 1'b0, '0);
      checks++; if (instr_valid_o !== 1'b1 || instr_o !== 16'h1000 || instr_pc_o !== 16'h0) begin
         errors++; $display("FAIL rstmid_c2 got v=%b instr=%h pc=%h exp v=1 instr=1000 pc=0000", instr_valid_o, instr_o, instr_pc_o); end
   endtask

   // Model: instructions come out in program order from the last redirect target;
   // reads cover consecutive addresses; issued-minus-consumed never exceeds DEPTH.
   task automatic test_random();
      logic [15:0] exp_pc, exp_fa, exp_ext, tgt;
      logic        adv, load, two, exp_rd, exp_valid, infl_m;
      int          iss, cons, since, len, pops, occ;
      hold_reset();
      @(negedge clk);
      exp_pc = 16'h0; exp_fa = 16'h0; iss = 0; cons = 0; since = 0; infl_m = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         adv  = ($urandom_range(0, 9) < 7);
         load = ($urandom_range(0, 19) == 0);
         tgt  = ($urandom_range(0, 3) == 0) ? 16'h01FE + 16'($urandom_range(0, 4)) : 16'($urandom);
         drive(adv, load, tgt);
         since++;
         two     = is_two(mem_fn(exp_pc));
         len     = two ? 2 : 1;
         exp_ext = two ? mem_fn(exp_pc + 16'h1) : 16'h0;
         occ       = iss - cons - (infl_m ? 1 : 0);
         exp_valid = (occ >= len);
         pops      = (exp_valid && adv) ? len : 0;
         exp_rd    = !load && ((iss - cons - pops) < DEPTH);
         checks++; if (mem_rd_o !== exp_rd) begin
            errors++; $display("FAIL rnd_rd cyc=%0d got=%b exp=%b", cyc, mem_rd_o, exp_rd); end
         checks++; if (instr_valid_o !== exp_valid) begin
            errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, instr_valid_o, exp_valid); end
         if (since <= 2) begin
            checks++; if (instr_valid_o !== 1'b0) begin
               errors++; $display("FAIL rnd_bubble cyc=%0d got=%b exp=0", cyc, instr_valid_o); end
         end
         if (exp_valid) begin
            checks++;
            if (instr_o !== mem_fn(exp_pc) || instr_pc_o !== exp_pc || instr_ext_o !== exp_ext) begin
               errors++; $display("FAIL rnd_instr cyc=%0d got instr=%h ext=%h pc=%h exp instr=%h ext=%h pc=%h",
                                  cyc, instr_o, instr_ext_o, instr_pc_o, mem_fn(exp_pc), exp_ext, exp_pc);
            end
         end else begin
            checks++;
            if (instr_o !== 16'h0 || instr_ext_o !== 16'h0) begin
               errors++; $display("FAIL rnd_nop cyc=%0d got instr=%h ext=%h exp 0000", cyc, instr_o, instr_ext_o);
            end
         end
         if (load) begin
            exp_pc = tgt; exp_fa = tgt; since = 0; iss = 0; cons = 0; infl_m = 1'b0;
         end else begin
            if (mem_rd_o === 1'b1) begin
               checks++; if (mem_addr_o !== exp_fa) begin
                  errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, mem_addr_o, exp_fa); end
               exp_fa = exp_fa + 16'h1;
               iss++;
            end
            infl_m = (mem_rd_o === 1'b1);
            cons   = cons + pops;
            exp_pc = exp_pc + 16'(pops);
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_advance();
      test_wrap();
      test_two_word();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/avr_ifetch.md
# avr_ifetch

Instruction fetch unit between `avr_cpu` and a synchronous program memory; the program-memory end of the CPU's `instr`/`p_addr` path. Issues word reads from a PC-driven fetch pointer, buffers returned words in a small prefetch queue, and presents one instruction per cycle to the CPU core with a valid/advance handshake. Redirects (jumps, branches, calls, returns) flush the queue and restart fetch at the target.

## Interface
- `AW`, 16: program word-address width.
- `DEPTH`, 4: prefetch queue entries; power of two, minimum 2.
- `CLK` in 1: clock; all state updates on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `pc_load` in 1: redirect request; `pc_target` becomes the next fetch address.
- `pc_target` in AW: redirect word address.
- `advance` in 1: CPU consumes the presented instruction.
- `instr` out 16: head instruction word; 16'h0000 (NOP) when `instr_valid`=0.
- `instr_ext` out 16: second word of a 32-bit instruction, else 0.
- `instr_valid` out 1: `instr` (and `instr_ext`) hold a complete instruction.
- `instr_pc` out AW: word address of `instr`.
- `mem_rd` out 1: program memory read strobe.
- `mem_addr` out AW: program memory word address.
- `mem_rdata` in 16: read data, valid exactly one cycle after the `mem_rd` cycle.

## Operation
- State: fetch pointer `fptr` (AW), queue of {word, pc}, in-flight flag `infl`, epoch bit.
- Issue rule: `mem_rd`=1 when occupancy + `infl` − pops this cycle < DEPTH and no `pc_load`. `mem_addr`=`fptr`; `fptr` increments by 1 on issue and wraps modulo 2^AW.
- Return: a word arriving while `infl`=1 and epoch matches is pushed with its pc; otherwise it is discarded.
- Pop: `advance`=1 with `instr_valid`=1 pops 1 entry (or 2 for a two-word instruction, see Configuration). `advance` with `instr_valid`=0 is ignored.
- Redirect: `pc_load`=1 clears the queue, toggles the epoch (the outstanding return is dropped), and sets `fptr`=`pc_target`. `pc_load` takes priority over a simultaneous `advance` and a simultaneous return.
- Queue full with a read in flight: impossible by the issue rule; a return never overflows.
- Reset: queue empty, `fptr`=0, `infl`=0, epoch=0. All outputs are 0: `instr`=0, `instr_ext`=0, `instr_valid`=0, `instr_pc`=0, `mem_rd`=0, `mem_addr`=0. This is identical when `RST` is asserted mid-operation, and any in-flight return is discarded.

## Timing
- After reset: the first cycle with `RST` low is c0, and c0 issues addr 0. Data returns in c1 and is written at the c1 edge. `instr_valid`=1 in c2 with `instr_pc`=0.
- Redirect asserted in cycle n: `mem_addr`=target with `mem_rd`=1 in n+1. Data returns in n+2. `instr_valid`=1 in n+3. `instr_valid`=0 in n+1 and n+2.
- Steady state with `advance` held high: one instruction per cycle, with no bubbles once the queue is primed.
- `instr`, `instr_pc` and `instr_valid` are driven from registered queue state only. There is no combinational path from `mem_rdata` or `advance` to these outputs.

## Configuration
- `IFETCH_TWO_WORD_EN` defined:
  - Decode the head for 32-bit opcodes: JMP/CALL (1001_010x_xxxx_11xx) and LDS/STS (1001_00xx_xxxx_0000).
  - For such a head, `instr_valid`=1 only when the next entry is also present; `instr_ext` is that entry's word.
  - `advance` pops 2 entries.
- `IFETCH_TWO_WORD_EN` undefined:
  - Every word is a one-word instruction.
  - `instr_ext` is tied to 0 and `advance` always pops 1 entry.

## Structure
- Shared package `avr_pkg`:
  - `AVR_NOP` constant (16'h0000).
  - Two-word opcode masks and match values.
  - Function `avr_is_two_word(word)`.
  - Queue entry typedef {word, pc}.
- Sub-module `avr_ifetch_fifo`: DEPTH-entry circular buffer with push, pop1/pop2, flush, occupancy count, and head/head+1 read ports.

## Test plan
- Reset, then memory returns addr+16'h1000 with `advance` held high → `instr`=16'h1000, 16'h1001, 16'h1002 on consecutive cycles starting c2, with `instr_pc` 0, 1, 2.
- `advance` held low for 10 cycles → `mem_rd` stops after DEPTH words are buffered, `instr` stays 16'h1000, and no word is lost once `advance` resumes.
- `pc_load` with target 16'h0040 while a read is in flight → the stale return is dropped. `instr_valid`=0 for two cycles, then `instr`=16'h1040 with `instr_pc`=16'h0040.
- `pc_load` and `advance` in the same cycle → redirect only, and the first instruction after redirect is the target word.
- Fetch pointer at 2^AW−1 → the next `mem_addr` is 0 (wrap).
- With `IFETCH_TWO_WORD_EN`, memory holds 16'h940C, 16'h0123 (JMP) → `instr`=16'h940C and `instr_ext`=16'h0123 in one valid cycle, then `instr_pc` advances by 2. With `RST` pulsed mid-stream → all outputs are 0 the next cycle.
